seq_frame_controller: RTL and testbench
=======================================

// Module: seq_frame_controller
// PURPOSE
//  Sequences the serial sequence detector and consumes its payload. Generates the detector's
//  clock-enable and a start-of-run clear. Deserialises the PAYLOAD_W bits that follow each
//  detected header into a parallel word. Hands the word downstream over a valid/ready
//  handshake. Sits between the switch/serial front end and the display/consumer logic.
// PARAMETERS
//  DIV        4   detEn period in clk cycles (>=1; DIV=1 -> detEn every RUN/CAP cycle)
//  PAYLOAD_W  10  payload bits per frame (the detector streams 10 valid bits after the header)
//  CNT_W      8   width of frameCnt
// PORTS
//  clk         in   1          system clock, all state updates on posedge
//  rst         in   1          synchronous, active-high reset
//  start       in   1          level/pulse; IDLE -> begin a run
//  stop        in   1          abort run; has priority over start
//  detValid    in   1          detector serOutValid
//  detBit      in   1          detector serOut
//  detEn       out  1          clkEn strobe to detector, 1-cycle pulse
//  detRst      out  1          1-cycle clear to detector at run start
//  busy        out  1          state != IDLE
//  frameData   out  PAYLOAD_W  captured word, first received bit in MSB
//  frameValid  out  1          frameData holds an unaccepted word
//  frameReady  in   1          downstream accepts when frameValid & frameReady
//  frameCnt    out  CNT_W      words committed to frameData, wraps 2^CNT_W-1 -> 0
//  overflow    out  1          sticky: a completed word was dropped; cleared by rst or start
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; prescaler, bitCnt and shift register 0.
//  FSM: IDLE --start&!stop--> CLR. CLR: detRst=1 for one cycle, overflow<=0 -> RUN.
//   RUN --tick&detValid--> CAP. Shift in detBit, bitCnt<=1.
//   CAP --tick&detValid--> shift, bitCnt++. At bitCnt==PAYLOAD_W, commit and go to RUN.
//   CAP --tick&!detValid--> discard the short frame, bitCnt<=0 -> RUN. No error is flagged.
//   stop in CLR/RUN/CAP -> IDLE next cycle. Partial word is discarded.
//   stop leaves frameData, frameValid, frameCnt and overflow untouched.
//   start while busy is ignored.
//  Prescaler: counts 0..DIV-1 only in RUN/CAP and is cleared in IDLE/CLR.
//   tick = (cnt==DIV-1). detEn = tick. The first detEn comes DIV cycles after entering RUN.
//  Sampling: detBit/detValid are sampled only on a tick cycle. They are not sampled otherwise.
//  Commit: performed on the clk edge of the last tick. frameValid=1 from the next cycle.
//   Latency is 1 clk from the last sampled bit.
//   Commit when !frameValid, or when frameValid&frameReady in the same cycle:
//   load frameData, frameValid stays or becomes 1, frameCnt++.
//   Commit when frameValid&!frameReady: the new word is dropped and overflow<=1.
//   frameData and frameCnt are unchanged.
//  Accept without commit: frameValid<=0. frameData holds its last value.
//  frameValid/frameData/frameCnt/overflow are never changed by the detector or FSM other than as above.
// CONFIGURATION
//  FRAME_PARITY_EN defined: the last payload bit is treated as even parity over the word.
//   Adds output frameParErr (1 bit). It is registered with frameData on commit:
//   1 if the XOR of all PAYLOAD_W bits is 1.
//   It is reset to 0 and held with frameData while that word is waiting.
//  FRAME_PARITY_EN undefined: no frameParErr port. All bits are treated as plain data.
// STRUCTURE
//  Package seq_ctrl_pkg: state encoding localparams IDLE/CLR/RUN/CAP (2-bit).
//   It also holds the PAYLOAD_W default.
//  Sub-module en_prescaler (DIV parameter; clk, rst, run -> tick), instantiated once.
//  FSM, shift register, bitCnt and the output/handshake register stay in this module.
// TESTING
//  1 rst held 2 cycles mid-CAP -> all outputs 0, state IDLE, detEn silent.
//  2 DIV=4, start, detector model streams header 11010 then bits 1011001110.
//    Expect detRst pulse, then detEn every 4 clk.
//    Expect frameData=10'b1011001110, frameValid=1 one clk after the 10th tick, frameCnt=1.
//  3 frameReady=0, two frames in a row -> first word kept, overflow=1, frameCnt=1.
//    Then frameReady=1 -> frameValid=0 next cycle.
//  4 commit cycle coincides with frameReady=1 while holding a word -> new word loaded,
//    frameValid stays 1, frameCnt+1.
//  5 stop after 5 payload bits -> IDLE next cycle, no commit, detEn stops.
//    Restart captures the next frame correctly from bit 0.
//  6 CNT_W=2, 5 accepted frames -> frameCnt 1,2,3,0,1.
//    With FRAME_PARITY_EN, word 10'b1000000000 -> frameParErr=1.

Source files
------------

// File: rtl/seq_frame_controller_pkg.sv
// Shared types for the serial-detector frame controller.
// State encoding and the default payload width live here.
package seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        CAP  = 2'd3
    } state_t;

    localparam int PAYLOAD_W_DEF = 10;

endpackage

// File: rtl/seq_frame_controller_en_prescaler.sv
// Clock-enable prescaler: one-cycle tick every DIV cycles while run is high.
// The count restarts from zero whenever run drops.
module en_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic          wrap;

    assign wrap = (cnt_q == CW'(DIV - 1));
    assign tick = run && wrap;

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt_q <= '0;
        end else if (wrap) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/seq_frame_controller.sv
// Drives the sequence detector and deserialises its payload into a valid/ready word.
// Optional FRAME_PARITY_EN adds frameParErr (even parity over the captured word).
module seq_frame_controller
    import seq_ctrl_pkg::*;
#(
    parameter int DIV       = 4,
    parameter int PAYLOAD_W = PAYLOAD_W_DEF,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 detValid,
    input  logic                 detBit,
    output logic                 detEn,
    output logic                 detRst,
    output logic                 busy,
    output logic [PAYLOAD_W-1:0] frameData,
    output logic                 frameValid,
    input  logic                 frameReady,
    output logic [CNT_W-1:0]     frameCnt,
    output logic                 overflow
`ifdef FRAME_PARITY_EN
    ,output logic                frameParErr
`endif
);

    localparam int BW = $clog2(PAYLOAD_W + 1);

    state_t                 state_q;
    logic [BW-1:0]          bitCnt_q;
    logic [PAYLOAD_W-1:0]   shreg_q;
    logic                   detRst_q;
    logic                   busy_q;
    logic [PAYLOAD_W-1:0]   frameData_q;
    logic                   frameValid_q;
    logic [CNT_W-1:0]       frameCnt_q;
    logic                   overflow_q;
    logic                   parErr_q;

    logic                   run;
    logic                   tick;
    logic [PAYLOAD_W:0]     shift_ext;
    logic [PAYLOAD_W-1:0]   word_d;
    logic [BW-1:0]          bitCnt_d;
    logic                   capture;
    logic                   commit;
    logic                   accept;

    assign run       = (state_q == RUN) || (state_q == CAP);
    assign shift_ext = {shreg_q, detBit};
    assign word_d    = shift_ext[PAYLOAD_W-1:0];
    assign bitCnt_d  = (state_q == CAP) ? bitCnt_q + BW'(1) : BW'(1);
    assign capture   = run && tick && detValid && !stop;
    assign commit    = capture && (bitCnt_d == BW'(PAYLOAD_W));
    assign accept    = frameValid_q && frameReady;

    en_prescaler #(.DIV(DIV)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bitCnt_q     <= '0;
            shreg_q      <= '0;
            detRst_q     <= 1'b0;
            busy_q       <= 1'b0;
            frameData_q  <= '0;
            frameValid_q <= 1'b0;
            frameCnt_q   <= '0;
            overflow_q   <= 1'b0;
            parErr_q     <= 1'b0;
        end else begin
            detRst_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        state_q  <= CLR;
                        detRst_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                CLR: begin
                    if (stop) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q    <= RUN;
                        overflow_q <= 1'b0;
                        bitCnt_q   <= '0;
                    end
                end
                RUN, CAP: begin
                    if (stop) begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        bitCnt_q <= '0;
                    end else if (tick) begin
                        if (detValid) begin
                            shreg_q <= word_d;
                            if (commit) begin
                                state_q  <= RUN;
                                bitCnt_q <= '0;
                            end else begin
                                state_q  <= CAP;
                                bitCnt_q <= bitCnt_d;
                            end
                        end else begin
                            // a gap in detValid ends a short frame; it is dropped silently
                            state_q  <= RUN;
                            bitCnt_q <= '0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            // a held word can be replaced only when it is accepted in the commit cycle
            if (commit) begin
                if (!frameValid_q || frameReady) begin
                    frameData_q  <= word_d;
                    frameValid_q <= 1'b1;
                    frameCnt_q   <= frameCnt_q + CNT_W'(1);
                    parErr_q     <= ^word_d;
                end else begin
                    overflow_q <= 1'b1;
                end
            end else if (accept) begin
                frameValid_q <= 1'b0;
            end
        end
    end

    assign detEn      = tick;
    assign detRst     = detRst_q;
    assign busy       = busy_q;
    assign frameData  = frameData_q;
    assign frameValid = frameValid_q;
    assign frameCnt   = frameCnt_q;
    assign overflow   = overflow_q;
`ifdef FRAME_PARITY_EN
    assign frameParErr = parErr_q;
`else
    logic unused_par;
    assign unused_par = parErr_q;
`endif

endmodule

// File: tb/tb_seq_frame_controller.sv
// Self-checking bench for seq_frame_controller with a queue-based detector stream
// and a frame-level reference model; also covers FRAME_PARITY_EN when defined.
module tb_seq_frame_controller;

    localparam int DIV   = 4;
    localparam int W     = 10;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             stop;
    logic             detValid;
    logic             detBit;
    logic             detEn;
    logic             detRst;
    logic             busy;
    logic [W-1:0]     frameData;
    logic             frameValid;
    logic             frameReady;
    logic [CNT_W-1:0] frameCnt;
    logic             overflow;
`ifdef FRAME_PARITY_EN
    logic             frameParErr;
`endif

    seq_frame_controller #(.DIV(DIV), .PAYLOAD_W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .detValid   (detValid),
        .detBit     (detBit),
        .detEn      (detEn),
        .detRst     (detRst),
        .busy       (busy),
        .frameData  (frameData),
        .frameValid (frameValid),
        .frameReady (frameReady),
        .frameCnt   (frameCnt),
        .overflow   (overflow)
`ifdef FRAME_PARITY_EN
        ,.frameParErr (frameParErr)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // detector stream: one {valid,bit} item is consumed per detEn
    logic [1:0] strm[$];

    // reference model: 0 idle, 1 clear, 2 running
    int         m_mode;
    int         m_k;
    bit         m_bits[$];
    logic [W-1:0] m_fd;
    bit         m_fv;
    int         m_cnt;
    bit         m_ov;
    bit         m_pe;

    typedef struct {
        logic [W-1:0] word;
        int           exp_cnt;
        bit           exp_pe;
    } vec_t;
    vec_t tbl[5];

    function automatic bit exp_detEn();
        return (m_mode == 2) && ((m_k % DIV) == DIV - 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_update();
        bit           acc;
        bit           com;
        bit           tk;
        logic [W-1:0] w;
        acc = m_fv && frameReady;
        com = 0;
        w   = '0;
        if (rst) begin
            m_mode = 0; m_k = 0; m_bits.delete();
            m_fd = '0; m_fv = 0; m_cnt = 0; m_ov = 0; m_pe = 0;
        end else begin
            case (m_mode)
                0: if (start && !stop) m_mode = 1;
                1: begin
                    if (stop) m_mode = 0;
                    else begin m_mode = 2; m_k = 0; m_ov = 0; m_bits.delete(); end
                end
                default: begin
                    if (stop) begin
                        m_mode = 0;
                        m_bits.delete();
                    end else begin
                        tk = ((m_k % DIV) == DIV - 1);
                        m_k++;
                        if (tk) begin
                            if (detValid) begin
                                m_bits.push_back(detBit);
                                if (m_bits.size() == W) begin
                                    com = 1;
                                    foreach (m_bits[i]) w = {w[W-2:0], m_bits[i]};
                                    m_bits.delete();
                                end
                            end else begin
                                m_bits.delete();
                            end
                        end
                    end
                end
            endcase
            if (com) begin
                if (!m_fv || frameReady) begin
                    m_fd = w; m_fv = 1; m_cnt = (m_cnt + 1) % (1 << CNT_W); m_pe = ^w;
                end else begin
                    m_ov = 1;
                end
            end else if (acc) begin
                m_fv = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("detEn", detEn, exp_detEn());
        chk("detRst", detRst, m_mode == 1);
        chk("busy", busy, m_mode != 0);
        chk("frameValid", frameValid, m_fv);
        chk("frameData", frameData, m_fd);
        chk("frameCnt", frameCnt, m_cnt);
        chk("overflow", overflow, m_ov);
`ifdef FRAME_PARITY_EN
        chk("frameParErr", frameParErr, m_pe);
`endif
    endtask

    task automatic cyc();
        if (exp_detEn()) begin
            if (strm.size() > 0) {detValid, detBit} = strm.pop_front();
            else {detValid, detBit} = 2'b00;
        end else begin
            {detValid, detBit} = 2'($urandom_range(0, 3));
        end
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic push_frame(input logic [W-1:0] word, input int len, input int gap);
        for (int i = 0; i < gap; i++) strm.push_back(2'b00);
        for (int i = W - 1; i >= W - len; i--) strm.push_back({1'b1, word[i]});
    endtask

    task automatic run_stream();
        int n = 0;
        while (strm.size() > 0 && n < 2000) begin
            cyc();
            n++;
        end
        chk("stream_drain", strm.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        logic [W-1:0] wa, wb;
        tbl[0] = '{10'b1011001110, 1, 1'b0};
        tbl[1] = '{10'b1000000000, 2, 1'b1};
        tbl[2] = '{10'b0000000011, 3, 1'b0};
        tbl[3] = '{10'b1111111111, 0, 1'b0};
        tbl[4] = '{10'b0101010101, 1, 1'b1};

        rst = 1; start = 0; stop = 0; frameReady = 0; detValid = 0; detBit = 0;
        m_mode = 0; m_k = 0; m_fd = '0; m_fv = 0; m_cnt = 0; m_ov = 0; m_pe = 0;
        cyc(); cyc();
        rst = 0;
        cyc();

        // start a run, then table-driven frames with a wrapping frame count
        start = 1; cyc(); start = 0;
        chk("detRst_pulse", detRst, 1);
        cyc();
        chk("detRst_one_cycle", detRst, 0);
        for (int i = 0; i < 5; i++) begin
            push_frame(tbl[i].word, W, 5);
            run_stream();
            chk("tbl_data", frameData, tbl[i].word);
            chk("tbl_valid", frameValid, 1);
            chk("tbl_cnt", frameCnt, tbl[i].exp_cnt);
`ifdef FRAME_PARITY_EN
            chk("tbl_parerr", frameParErr, tbl[i].exp_pe);
`endif
            frameReady = 1; cyc(); frameReady = 0;
            chk("tbl_accept", frameValid, 0);
        end

        // two frames with no acceptance: first kept, second dropped
        c0 = m_cnt; wa = 10'b1100110011; wb = 10'b0011001100;
        push_frame(wa, W, 5);
        push_frame(wb, W, 5);
        run_stream();
        chk("ovf_data", frameData, wa);
        chk("ovf_flag", overflow, 1);
        chk("ovf_cnt", frameCnt, (c0 + 1) % 4);
        frameReady = 1; cyc(); frameReady = 0;
        chk("ovf_accept", frameValid, 0);

        // commit coinciding with acceptance of a held word
        c0 = m_cnt; wa = 10'b1110001110; wb = 10'b0001110001;
        push_frame(wa, W, 3);
        run_stream();
        push_frame(wb, W, 3);
        for (int n = 0; n < 2000 && strm.size() > 0; n++) begin
            logic [1:0] hd;
            hd = strm[0];
            frameReady = exp_detEn() && (m_bits.size() == W - 1) && hd[1];
            cyc();
        end
        frameReady = 0;
        chk("swap_data", frameData, wb);
        chk("swap_valid", frameValid, 1);
        chk("swap_cnt", frameCnt, (c0 + 2) % 4);

        // stop after 5 payload bits, then restart
        frameReady = 1;
        c0 = m_cnt;
        push_frame(10'b1010101010, W, 2);
        for (int n = 0; n < 500 && m_bits.size() < 5; n++) cyc();
        chk("stop_bits", m_bits.size(), 5);
        stop = 1; cyc(); stop = 0;
        chk("stop_busy", busy, 0);
        strm.delete();
        for (int i = 0; i < 8; i++) cyc();
        chk("stop_nocommit", frameCnt, c0);
        start = 1; cyc(); start = 0;
        push_frame(10'b0110011001, W, 4);
        run_stream();
        chk("restart_data", frameData, 10'b0110011001);
        chk("restart_cnt", frameCnt, (c0 + 1) % 4);

        // reset held two cycles in the middle of a capture
        push_frame(10'b1111100000, W, 1);
        for (int n = 0; n < 500 && m_bits.size() < 3; n++) cyc();
        rst = 1; cyc(); cyc(); rst = 0;
        strm.delete();
        chk("rst_valid", frameValid, 0);
        chk("rst_cnt", frameCnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_detEn", detEn, 0);
        chk("rst_data", frameData, 0);
        for (int i = 0; i < 6; i++) cyc();

        // randomized traffic against the reference model
        start = 1; cyc(); start = 0;
        for (int i = 0; i < 1500; i++) begin
            if (strm.size() < 2) begin
                int len;
                len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W - 1)) : W;
                push_frame(W'($urandom), len, $urandom_range(1, 6));
            end
            start      = ($urandom_range(0, 19) == 0);
            stop       = ($urandom_range(0, 59) == 0);
            frameReady = $urandom_range(0, 1);
            cyc();
        end
        start = 0; stop = 0; frameReady = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
